xif_coproc_router: RTL and testbench

//  Routes the core's eXtension-interface traffic to NUM_COPROC coprocessors instead of a single one.

---
 rtl/xif_coproc_router.sv | 221 ++++++++++++++++++++++
 tb/tb_xif_coproc_router.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_coproc_router.sv
// Routes eXtension-interface issue/commit/result traffic between one core and
// NUM_COPROC coprocessors. Issue is steered by custom opcode, commit follows the
// owner of the instruction id, and results are merged round-robin into a register.
module xif_coproc_router #(
   parameter int NUM_COPROC      = 2,
   parameter int X_NUM_RS        = 2,
   parameter int X_ID_WIDTH      = 4,
   parameter int X_RFR_WIDTH     = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   issue_valid_i,
   output logic                                   issue_ready_o,
   output logic                                   issue_accept_o,
   input  logic [31:0]                            issue_instr_i,
   input  logic [X_ID_WIDTH-1:0]                  issue_id_i,
   input  logic [X_NUM_RS*X_RFR_WIDTH-1:0]        issue_rs_i,
   output logic [NUM_COPROC-1:0]                  cp_issue_valid_o,
   input  logic [NUM_COPROC-1:0]                  cp_issue_ready_i,
   input  logic [NUM_COPROC-1:0]                  cp_issue_accept_i,
   output logic [31:0]                            cp_issue_instr_o,
   output logic [X_ID_WIDTH-1:0]                  cp_issue_id_o,
   output logic [X_NUM_RS*X_RFR_WIDTH-1:0]        cp_issue_rs_o,
   input  logic                                   commit_valid_i,
   input  logic [X_ID_WIDTH-1:0]                  commit_id_i,
   input  logic                                   commit_kill_i,
   output logic [NUM_COPROC-1:0]                  cp_commit_valid_o,
   output logic [X_ID_WIDTH-1:0]                  cp_commit_id_o,
   output logic                                   cp_commit_kill_o,
   input  logic [NUM_COPROC-1:0]                  cp_result_valid_i,
   output logic [NUM_COPROC-1:0]                  cp_result_ready_o,
   input  logic [NUM_COPROC-1:0][X_ID_WIDTH-1:0]  cp_result_id_i,
   input  logic [NUM_COPROC-1:0][X_RFR_WIDTH-1:0] cp_result_data_i,
   input  logic [NUM_COPROC-1:0][4:0]             cp_result_rd_i,
   input  logic [NUM_COPROC-1:0]                  cp_result_we_i,
   output logic                                   result_valid_o,
   input  logic                                   result_ready_i,
   output logic [X_ID_WIDTH-1:0]                  result_id_o,
   output logic [X_RFR_WIDTH-1:0]                 result_data_o,
   output logic [4:0]                             result_rd_o,
   output logic                                   result_we_o,
   output logic                                   protocol_err_o
);

   localparam int NUM_IDS = 1 << X_ID_WIDTH;

   logic [1:0]                  owner_q [NUM_IDS];
   logic [NUM_IDS-1:0]          vld_q;
   logic [NUM_COPROC-1:0][3:0]  cnt_q, cnt_d;
   logic [1:0]                  rr_q, rr_d, src_q;
   logic                        sat_err;

   logic [1:0] sel;
   logic       routable, full, issue_hs;
   logic [1:0] c_owner, r_owner;
   logic       c_vld, kill_ok, kill_dec, commit_err;
   logic       free, gnt_vld, ret_hs, ret_ok, ret_err;
   logic [1:0] gnt;
   logic [X_ID_WIDTH-1:0]  g_id;
   logic [X_RFR_WIDTH-1:0] g_data;
   logic [4:0]             g_rd;
   logic                   g_we;

   // Operands and ids are broadcast; only the valid strobes are steered.
   assign cp_issue_instr_o = issue_instr_i;
   assign cp_issue_id_o    = issue_id_i;
   assign cp_issue_rs_o    = issue_rs_i;
   assign cp_commit_id_o   = commit_id_i;
   assign cp_commit_kill_o = commit_kill_i;

   assign sel      = issue_instr_i[6:5];
   assign routable = (issue_instr_i[4:0] == 5'b01011) && (32'(sel) < NUM_COPROC);

   // Issue steering; a full channel stalls the core instead of offloading.
   always_comb begin
      issue_ready_o    = 1'b0;
      issue_accept_o   = 1'b0;
      cp_issue_valid_o = '0;
      full             = 1'b0;
      for (int k = 0; k < NUM_COPROC; k++)
         if (routable && sel == 2'(k) && cnt_q[k] == 4'(MAX_OUTSTANDING)) full = 1'b1;
      if (rst_ni) begin
         if (!routable) begin
            issue_ready_o = issue_valid_i;
         end else if (!full) begin
            for (int k = 0; k < NUM_COPROC; k++) begin
               if (sel == 2'(k)) begin
                  cp_issue_valid_o[k] = issue_valid_i;
                  issue_ready_o       = cp_issue_ready_i[k];
                  issue_accept_o      = cp_issue_accept_i[k];
               end
            end
         end
      end
   end

   assign issue_hs = issue_valid_i && issue_ready_o && issue_accept_o && routable;

   // Commit follows the owner table; unknown ids are dropped and flagged.
   assign c_owner    = owner_q[commit_id_i];
   assign c_vld      = vld_q[commit_id_i];
   assign kill_ok    = commit_valid_i && commit_kill_i && c_vld;
   assign commit_err = commit_valid_i && !c_vld;

   // One-hot commit strobe to the owning channel only.
   always_comb begin
      cp_commit_valid_o = '0;
      for (int k = 0; k < NUM_COPROC; k++)
         cp_commit_valid_o[k] = rst_ni && commit_valid_i && c_vld && (c_owner == 2'(k));
   end

   assign free    = !result_valid_o || result_ready_i;
   assign ret_hs  = result_valid_o && result_ready_i;
   assign r_owner = owner_q[result_id_o];
   assign ret_ok  = ret_hs && vld_q[result_id_o] && (r_owner == src_q);
   assign ret_err = ret_hs && !ret_ok;
   // A kill and a clean retire of the same id must release the slot only once.
   assign kill_dec = kill_ok && !(ret_ok && commit_id_i == result_id_o);

   // Round-robin search starting at rr_q, plus field mux of the winner.
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = '0;
      g_id    = '0;
      g_data  = '0;
      g_rd    = '0;
      g_we    = 1'b0;
      for (int i = 0; i < NUM_COPROC; i++) begin
         int idx;
         idx = (int'(rr_q) + i) % NUM_COPROC;
         if (!gnt_vld && cp_result_valid_i[idx]) begin
            gnt_vld = 1'b1;
            gnt     = 2'(idx);
         end
      end
      for (int k = 0; k < NUM_COPROC; k++) begin
         if (gnt == 2'(k)) begin
            g_id   = cp_result_id_i[k];
            g_data = cp_result_data_i[k];
            g_rd   = cp_result_rd_i[k];
            g_we   = cp_result_we_i[k];
         end
      end
      rr_d = (int'(gnt) + 1 == NUM_COPROC) ? 2'd0 : gnt + 2'd1;
   end

   // Grant is combinational so the channel sees ready in the loading cycle.
   always_comb begin
      cp_result_ready_o = '0;
      for (int k = 0; k < NUM_COPROC; k++)
         cp_result_ready_o[k] = rst_ni && free && gnt_vld && (gnt == 2'(k));
   end

   // Per-channel outstanding counters; never wrap, saturate at 0 with an error.
   always_comb begin
      cnt_d   = cnt_q;
      sat_err = 1'b0;
      for (int k = 0; k < NUM_COPROC; k++) begin
         logic [4:0] s, d;
         s = {1'b0, cnt_q[k]} + 5'(issue_hs && sel == 2'(k));
         d = 5'(kill_dec && c_owner == 2'(k)) + 5'(ret_ok && r_owner == 2'(k));
         if (s < d) begin
            cnt_d[k] = '0;
            sat_err  = 1'b1;
         end else begin
            cnt_d[k] = 4'(s - d);
         end
      end
   end

   // Owner table and in-flight bits; a same-cycle issue overrides any clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         for (int i = 0; i < NUM_IDS; i++) owner_q[i] <= '0;
      end else begin
         if (kill_ok) vld_q[commit_id_i] <= 1'b0;
         if (ret_ok)  vld_q[result_id_o] <= 1'b0;
         if (issue_hs) begin
            vld_q[issue_id_i]   <= 1'b1;
            owner_q[issue_id_i] <= sel;
         end
      end
   end

   // Counters, arbiter pointer and sticky error flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q          <= '0;
         rr_q           <= '0;
         protocol_err_o <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (free && gnt_vld) rr_q <= rr_d;
         if (commit_err || ret_err || sat_err) protocol_err_o <= 1'b1;
      end
   end

   // Result output register; holds while the core back-pressures.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         result_valid_o <= 1'b0;
         result_id_o    <= '0;
         result_data_o  <= '0;
         result_rd_o    <= '0;
         result_we_o    <= 1'b0;
         src_q          <= '0;
      end else if (free) begin
         result_valid_o <= gnt_vld;
         if (gnt_vld) begin
            result_id_o   <= g_id;
            result_data_o <= g_data;
            result_rd_o   <= g_rd;
            result_we_o   <= g_we;
            src_q         <= gnt;
         end
      end
   end

endmodule

// File: tb/tb_xif_coproc_router.sv
// Directed bench for xif_coproc_router: decode vector table plus hand-written
// sequences for commit/kill, result arbitration, back-pressure, reset and stall.
module tb_xif_coproc_router;
   logic clk, rst_n;
   logic issue_valid, issue_ready, issue_accept;
   logic [31:0] issue_instr;
   logic [3:0]  issue_id;
   logic [63:0] issue_rs;
   logic [1:0]  cp_issue_valid, cp_issue_ready, cp_issue_accept;
   logic [31:0] cp_issue_instr;
   logic [3:0]  cp_issue_id;
   logic [63:0] cp_issue_rs;
   logic        commit_valid, commit_kill;
   logic [3:0]  commit_id;
   logic [1:0]  cp_commit_valid;
   logic [3:0]  cp_commit_id;
   logic        cp_commit_kill;
   logic [1:0]  cp_result_valid, cp_result_ready;
   logic [1:0][3:0]  cp_result_id;
   logic [1:0][31:0] cp_result_data;
   logic [1:0][4:0]  cp_result_rd;
   logic [1:0]  cp_result_we;
   logic        result_valid, result_ready;
   logic [3:0]  result_id;
   logic [31:0] result_data;
   logic [4:0]  result_rd;
   logic        result_we, protocol_err;

   int checks = 0;
   int failures = 0;

   xif_coproc_router dut (
      .clk_i(clk), .rst_ni(rst_n),
      .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_accept_o(issue_accept),
      .issue_instr_i(issue_instr), .issue_id_i(issue_id), .issue_rs_i(issue_rs),
      .cp_issue_valid_o(cp_issue_valid), .cp_issue_ready_i(cp_issue_ready),
      .cp_issue_accept_i(cp_issue_accept), .cp_issue_instr_o(cp_issue_instr),
      .cp_issue_id_o(cp_issue_id), .cp_issue_rs_o(cp_issue_rs),
      .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
      .cp_commit_valid_o(cp_commit_valid), .cp_commit_id_o(cp_commit_id),
      .cp_commit_kill_o(cp_commit_kill),
      .cp_result_valid_i(cp_result_valid), .cp_result_ready_o(cp_result_ready),
      .cp_result_id_i(cp_result_id), .cp_result_data_i(cp_result_data),
      .cp_result_rd_i(cp_result_rd), .cp_result_we_i(cp_result_we),
      .result_valid_o(result_valid), .result_ready_i(result_ready),
      .result_id_o(result_id), .result_data_o(result_data), .result_rd_o(result_rd),
      .result_we_o(result_we), .protocol_err_o(protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        vi;
      logic [31:0] instr;
      logic [1:0]  rdy, acc;
      logic        e_rdy, e_acc;
      logic [1:0]  e_cpv;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      issue_valid = 0; issue_instr = 0; issue_id = 0; issue_rs = 0;
      cp_issue_ready = 0; cp_issue_accept = 0;
      commit_valid = 0; commit_id = 0; commit_kill = 0;
      cp_result_valid = 0; cp_result_id = '0; cp_result_data = '0;
      cp_result_rd = '0; cp_result_we = '0; result_ready = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic issue(input logic [31:0] instr, input logic [3:0] id, input logic [1:0] ra);
      issue_valid = 1; issue_instr = instr; issue_id = id;
      cp_issue_ready = ra; cp_issue_accept = ra;
   endtask

   initial begin
      // decode vectors: no handshake completes in any of these
      tbl[0] = '{1'b1, 32'h0000_0033, 2'b11, 2'b11, 1'b1, 1'b0, 2'b00};
      tbl[1] = '{1'b1, 32'h0000_005B, 2'b11, 2'b11, 1'b1, 1'b0, 2'b00};
      tbl[2] = '{1'b1, 32'h0000_007B, 2'b11, 2'b11, 1'b1, 1'b0, 2'b00};
      tbl[3] = '{1'b1, 32'h0000_000B, 2'b00, 2'b11, 1'b0, 1'b1, 2'b01};
      tbl[4] = '{1'b1, 32'h0000_002B, 2'b01, 2'b10, 1'b0, 1'b1, 2'b10};
      tbl[5] = '{1'b0, 32'h0000_000B, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00};
      tbl[6] = '{1'b1, 32'h0000_002B, 2'b10, 2'b00, 1'b1, 1'b0, 2'b10};
      tbl[7] = '{1'b1, 32'h0000_002F, 2'b11, 2'b11, 1'b1, 1'b0, 2'b00};

      idle_inputs();
      rst_n = 0;
      #3;
      chk("rst_result_valid", 64'(result_valid), 0);
      chk("rst_err", 64'(protocol_err), 0);
      chk("rst_issue_ready", 64'(issue_ready), 0);
      chk("rst_result_data", 64'(result_data), 0);
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 8; i++) begin
         issue_valid = tbl[i].vi; issue_instr = tbl[i].instr; issue_id = 4'(i);
         cp_issue_ready = tbl[i].rdy; cp_issue_accept = tbl[i].acc;
         #1;
         chk($sformatf("vec%0d_ready", i), 64'(issue_ready), 64'(tbl[i].e_rdy));
         chk($sformatf("vec%0d_accept", i), 64'(issue_accept), 64'(tbl[i].e_acc));
         chk($sformatf("vec%0d_cpv", i), 64'(cp_issue_valid), 64'(tbl[i].e_cpv));
         @(negedge clk);
      end
      idle_inputs();

      // custom-1 issue of id 3, then kill it twice
      issue(32'h0000_002B, 4'd3, 2'b10);
      #1;
      chk("c1_ready", 64'(issue_ready), 1);
      chk("c1_accept", 64'(issue_accept), 1);
      chk("c1_cpv", 64'(cp_issue_valid), 64'b10);
      @(negedge clk);
      idle_inputs();
      commit_valid = 1; commit_id = 4'd3; commit_kill = 1;
      #1;
      chk("kill_cpv", 64'(cp_commit_valid), 64'b10);
      chk("kill_flag", 64'(cp_commit_kill), 1);
      chk("kill_id", 64'(cp_commit_id), 3);
      @(negedge clk);
      chk("kill_err_clean", 64'(protocol_err), 0);
      #1;
      chk("kill2_cpv", 64'(cp_commit_valid), 0);
      @(negedge clk);
      commit_valid = 0;
      chk("kill2_err", 64'(protocol_err), 1);
      @(negedge clk);
      chk("err_sticky", 64'(protocol_err), 1);

      do_reset();
      chk("err_cleared", 64'(protocol_err), 0);

      // both channels return at once: ch0 first, then ch1
      issue(32'h0000_000B, 4'd1, 2'b01);
      @(negedge clk);
      issue(32'h0000_002B, 4'd2, 2'b10);
      @(negedge clk);
      idle_inputs();
      cp_result_valid = 2'b11;
      cp_result_id[0] = 4'd1; cp_result_data[0] = 32'hA1; cp_result_rd[0] = 5'd7;  cp_result_we[0] = 1;
      cp_result_id[1] = 4'd2; cp_result_data[1] = 32'hB2; cp_result_rd[1] = 5'd9;  cp_result_we[1] = 0;
      result_ready = 1;
      #1;
      chk("arb_gnt0", 64'(cp_result_ready), 64'b01);
      chk("arb_no_out_yet", 64'(result_valid), 0);
      @(negedge clk);
      chk("arb_t1_valid", 64'(result_valid), 1);
      chk("arb_t1_id", 64'(result_id), 1);
      chk("arb_t1_data", 64'(result_data), 32'hA1);
      chk("arb_t1_rd", 64'(result_rd), 7);
      cp_result_valid = 2'b10;
      #1;
      chk("arb_gnt1", 64'(cp_result_ready), 64'b10);
      @(negedge clk);
      chk("arb_t2_id", 64'(result_id), 2);
      chk("arb_t2_data", 64'(result_data), 32'hB2);
      chk("arb_t2_we", 64'(result_we), 0);

      // back-pressure with ch1 still offering a result
      result_ready = 0;
      cp_result_id[1] = 4'd9; cp_result_data[1] = 32'hC3;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("hold%0d_gnt", c), 64'(cp_result_ready), 0);
         chk($sformatf("hold%0d_id", c), 64'(result_id), 2);
         chk($sformatf("hold%0d_data", c), 64'(result_data), 32'hB2);
         chk($sformatf("hold%0d_valid", c), 64'(result_valid), 1);
         @(negedge clk);
      end
      chk("hold_err_clean", 64'(protocol_err), 0);
      #2;
      rst_n = 0;
      #1;
      chk("mid_rst_valid", 64'(result_valid), 0);
      chk("mid_rst_id", 64'(result_id), 0);
      chk("mid_rst_data", 64'(result_data), 0);
      chk("mid_rst_gnt", 64'(cp_result_ready), 0);
      idle_inputs();
      @(negedge clk);
      rst_n = 1;

      // outstanding limit on ch0
      for (int i = 0; i < 4; i++) begin
         issue(32'h0000_000B, 4'(i), 2'b01);
         #1;
         chk($sformatf("fill%0d_ready", i), 64'(issue_ready), 1);
         @(negedge clk);
      end
      issue(32'h0000_000B, 4'd4, 2'b01);
      #1;
      chk("full_ready", 64'(issue_ready), 0);
      chk("full_cpv", 64'(cp_issue_valid), 0);
      cp_result_valid = 2'b01; cp_result_id[0] = 4'd0; cp_result_data[0] = 32'h55;
      result_ready = 1;
      #1;
      chk("full_gnt", 64'(cp_result_ready), 64'b01);
      @(negedge clk);
      cp_result_valid = 2'b00;
      #1;
      chk("full_res_id", 64'(result_id), 0);
      chk("full_res_valid", 64'(result_valid), 1);
      chk("full_still_stall", 64'(issue_ready), 0);
      @(negedge clk);
      #1;
      chk("unstall_ready", 64'(issue_ready), 1);
      chk("unstall_accept", 64'(issue_accept), 1);
      chk("unstall_cpv", 64'(cp_issue_valid), 64'b01);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("end_result_valid", 64'(result_valid), 0);
      chk("end_err", 64'(protocol_err), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
